// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use stall detection.
// Feeds SrcA/SrcB/Operation to the ALU one cycle after ID presents an instruction.
module id_ex_operand_stage #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 4,
  parameter int unsigned REG_ADDR_W    = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [REG_ADDR_W-1:0]    id_rs1,
  input  logic [REG_ADDR_W-1:0]    id_rs2,
  input  logic [REG_ADDR_W-1:0]    id_rd,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic [OPCODE_LENGTH-1:0] id_alu_op,
  input  logic                     id_alu_src,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     id_mem_write,
  input  logic                     flush,
  input  logic                     exmem_reg_write,
  input  logic [REG_ADDR_W-1:0]    exmem_rd,
  input  logic [DATA_WIDTH-1:0]    exmem_result,
  input  logic                     memwb_reg_write,
  input  logic [REG_ADDR_W-1:0]    memwb_rd,
  input  logic [DATA_WIDTH-1:0]    memwb_result,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     ex_valid,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write,
  output logic [REG_ADDR_W-1:0]    ex_rd,
  output logic [DATA_WIDTH-1:0]    ex_store_data,
  output logic                     stall_id
);

  logic                     valid_q, valid_d;
  logic                     reg_write_q, reg_write_d;
  logic                     mem_read_q, mem_read_d;
  logic                     mem_write_q, mem_write_d;
  logic                     alu_src_q, alu_src_d;
  logic [REG_ADDR_W-1:0]    rd_q, rd_d;
  logic [REG_ADDR_W-1:0]    rs1_q, rs1_d;
  logic [REG_ADDR_W-1:0]    rs2_q, rs2_d;
  logic [DATA_WIDTH-1:0]    rs1_data_q, rs1_data_d;
  logic [DATA_WIDTH-1:0]    rs2_data_q, rs2_data_d;
  logic [DATA_WIDTH-1:0]    imm_q, imm_d;
  logic [OPCODE_LENGTH-1:0] alu_op_q, alu_op_d;

  logic [DATA_WIDTH-1:0]    fwd_a, fwd_b;

  // A load in EX cannot supply its data until MEM, so any ID reader of its rd must wait.
  assign stall_id = valid_q && mem_read_q && (rd_q != '0) && id_valid &&
                    ((id_rs1 == rd_q) || (id_rs2 == rd_q));

  // Next-state: bubble on flush, stall or an empty ID slot; otherwise capture ID.
  always_comb begin
    valid_d     = 1'b0;
    reg_write_d = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    alu_src_d   = 1'b0;
    rd_d        = '0;
    rs1_d       = '0;
    rs2_d       = '0;
    rs1_data_d  = '0;
    rs2_data_d  = '0;
    imm_d       = '0;
    alu_op_d    = '0;
    if (!flush && !stall_id && id_valid) begin
      valid_d     = 1'b1;
      reg_write_d = id_reg_write;
      mem_read_d  = id_mem_read;
      mem_write_d = id_mem_write;
      alu_src_d   = id_alu_src;
      rd_d        = id_rd;
      rs1_d       = id_rs1;
      rs2_d       = id_rs2;
      rs1_data_d  = id_rs1_data;
      rs2_data_d  = id_rs2_data;
      imm_d       = id_imm;
      alu_op_d    = id_alu_op;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      alu_src_q   <= 1'b0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      alu_op_q    <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      alu_src_q   <= alu_src_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      alu_op_q    <= alu_op_d;
    end
  end

  // Forwarding: the younger EX/MEM result wins over MEM/WB; x0 is never forwarded.
  always_comb begin
    fwd_a = rs1_data_q;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs1_q)) begin
      fwd_a = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs1_q)) begin
      fwd_a = memwb_result;
    end
  end

  always_comb begin
    fwd_b = rs2_data_q;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs2_q)) begin
      fwd_b = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs2_q)) begin
      fwd_b = memwb_result;
    end
  end

  assign SrcA          = fwd_a;
  assign SrcB          = alu_src_q ? imm_q : fwd_b;
  assign ex_store_data = fwd_b;
  assign Operation     = alu_op_q;
  assign ex_valid      = valid_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_rd         = rd_q;

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus EX-stage operand selection; sits directly upstream of the ALU.
- Captures decoded instruction fields from ID and forwards results from EX/MEM and MEM/WB.
- Drives SrcA, SrcB and Operation to the ALU.
- Detects load-use hazards, stalls ID and inserts a bubble.

Parameters:
- DATA_WIDTH, 32, register/operand width.
- OPCODE_LENGTH, 4, ALU operation code width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W  source and destination register indices.
- id_rs1_data, id_rs2_data  in  DATA_WIDTH  register-file read data.
- id_imm  in  DATA_WIDTH  sign-extended immediate.
- id_alu_op  in  OPCODE_LENGTH  ALU operation code.
- id_alu_src  in  1  1 selects id_imm as SrcB.
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits.
- flush  in  1  branch/jump redirect; kills the instruction entering EX.
- exmem_reg_write  in  1  EX/MEM stage writes a register.
- exmem_rd  in  REG_ADDR_W  EX/MEM destination register.
- exmem_result  in  DATA_WIDTH  EX/MEM result.
- memwb_reg_write  in  1  MEM/WB stage writes a register.
- memwb_rd  in  REG_ADDR_W  MEM/WB destination register.
- memwb_result  in  DATA_WIDTH  MEM/WB result.
- SrcA, SrcB  out  DATA_WIDTH  ALU operands.
- Operation  out  OPCODE_LENGTH  ALU operation code.
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered control bits.
- ex_rd  out  REG_ADDR_W  registered destination register.
- ex_store_data  out  DATA_WIDTH  forwarded rs2 value, for stores.
- stall_id  out  1  ID/IF must hold their current contents.

Behaviour:
- Reset:
  - All pipeline registers cleared: valid, control bits, rd, rs1, rs2, data, imm and alu_op all 0.
  - Outputs therefore read SrcA=0, SrcB=0, Operation=0, stall_id=0 (combinationally, from registered values).
- stall_id (combinational):
  - Asserts when ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (id_rs1==ex_rd | id_rs2==ex_rd).
  - Compare both rs fields regardless of instruction type.
- Register update each edge, priority reset > flush > stall_id > load:
  - flush or stall_id: load a bubble. valid, reg_write, mem_read and mem_write = 0; Operation = 0; remaining fields 0.
  - Otherwise: capture all id_* fields. id_valid=0 also loads a bubble.
- Latency: one cycle from ID inputs to registered EX fields.
- Forwarding is purely combinational; the same-cycle exmem/memwb values are used.
- Forwarding for rs1 (registered); rs2 is handled identically:
  - If exmem_reg_write & exmem_rd!=0 & exmem_rd==rs1: use exmem_result.
  - Else if memwb_reg_write & memwb_rd!=0 & memwb_rd==rs1: use memwb_result.
  - Else: use the registered rs1 data.
  - EX/MEM always beats MEM/WB.
  - x0 is never forwarded, so reading x0 yields the registered data (0 from the register file).
- Operand outputs:
  - SrcA = forwarded rs1.
  - ex_store_data = forwarded rs2.
  - SrcB = registered imm if alu_src=1, else forwarded rs2.
  - Operation = registered alu_op, passed unchanged. Shift-amount masking stays in the ALU.
- Bubble: SrcA and SrcB may carry forwarded values; downstream must qualify with ex_valid/ex_reg_write.
- Simultaneous stall and flush: flush wins (bubble). stall_id remains asserted combinationally and is harmless, because the redirect also flushes ID.
- Reset asserted mid-stall: the next edge clears everything and stall_id drops.

Test Plan:
- Reset, then deassert:
  - Expect SrcA=0, SrcB=0, Operation=0, ex_valid=0, stall_id=0.
- Plain ADD:
  - Stimulus: id_rs1_data=5, id_rs2_data=7, id_alu_op=0010, alu_src=0, no forwarding matches.
  - Next cycle: SrcA=5, SrcB=7, Operation=0010, ex_valid=1.
  - Repeat with alu_src=1, imm=0xFFFFFFFC: SrcB=0xFFFFFFFC.
- Double forward:
  - Stimulus: registered rs1=3, rs2=3; exmem_rd=3, exmem_result=0x11; memwb_rd=3, memwb_result=0x22; both reg_write=1.
  - Expect SrcA=SrcB=0x11.
  - Drop exmem_reg_write: expect 0x22.
  - Set rd=0 on both stages with rs=0: no forwarding, SrcA equals the registered data.
- Load-use:
  - Stimulus: EX holds lw x4 (mem_read=1, rd=4); ID has rs2=4.
  - Expect stall_id=1 in that cycle, and next cycle ex_valid=0, ex_reg_write=0, Operation=0.
  - Same case with ID rs1=rs2=5: stall_id=0.
- Flush and stall together:
  - Stimulus: flush=1 with a valid ID instruction, also with the load-use condition true.
  - Next cycle: bubble, with ex_mem_write=0.
- Reset mid-stall:
  - Stimulus: assert reset during a load-use stall.
  - Next cycle: all registers 0, stall_id=0.
